// File: rtl/ex_hilo_muldiv.sv
// EX-stage multiply/divide unit that owns the architectural HI/LO registers.
// MULT/MULTU/MTHI/MTLO commit in one cycle. DIV/DIVU use a restoring divider
// that produces one quotient bit per cycle and holds EX through
// stallreq_for_ex until the result is ready.
module ex_hilo_muldiv #(
    parameter int DIV_ITERS = 32,
    parameter int STALL_WD  = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STALL_WD-1:0] stall,
    input  logic                inst_mult,
    input  logic                inst_multu,
    input  logic                inst_div,
    input  logic                inst_divu,
    input  logic                inst_mfhi,
    input  logic                inst_mflo,
    input  logic                inst_mthi,
    input  logic                inst_mtlo,
    input  logic [31:0]         src_a,
    input  logic [31:0]         src_b,
    output logic [31:0]         hilo_rdata,
    output logic                stallreq_for_ex,
    output logic                div_busy,
    output logic [31:0]         hi_o,
    output logic [31:0]         lo_o
);

    localparam int CNT_W = $clog2(DIV_ITERS + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIV_ON  = 2'd1,
        DIV_END = 2'd2
    } div_state_e;

    div_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      rem_q;
    logic [31:0]      quot_q;
    logic [31:0]      dvsr_q;
    logic             qneg_q;
    logic             rneg_q;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    // EX moves on this edge only when ctrl is not holding stage 2.
    logic adv;
    assign adv = ~stall[2];

    // Only the EX bit of the stall bus matters here.
    logic unused_stall;
    assign unused_stall = ^{stall[STALL_WD-1:3], stall[1:0]};

    logic div_op;
    assign div_op = inst_div | inst_divu;

    // Operand magnitudes; signed DIV works on |a|/|b| and fixes signs at the end.
    // |0x80000000| stays 0x80000000, which is correct as an unsigned magnitude.
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    always_comb begin
        a_neg = inst_div & src_a[31];
        b_neg = inst_div & src_b[31];
        a_mag = a_neg ? -src_a : src_a;
        b_mag = b_neg ? -src_b : src_b;
    end

    // One restoring step: shift {rem,quot} left and subtract when it fits.
    // The shifted remainder can reach 33 bits, so the compare keeps the carry.
    logic [32:0] shl;
    logic [31:0] step_rem, step_quot;
    always_comb begin
        shl = {rem_q, quot_q[31]};
        if (shl >= {1'b0, dvsr_q}) begin
            step_rem  = shl[31:0] - dvsr_q;
            step_quot = {quot_q[30:0], 1'b1};
        end else begin
            step_rem  = shl[31:0];
            step_quot = {quot_q[30:0], 1'b0};
        end
    end

    // Signed results are re-applied as two's-complement negation.
    logic [31:0] quot_res, rem_res;
    always_comb begin
        quot_res = qneg_q ? -quot_q : quot_q;
        rem_res  = rneg_q ? -rem_q  : rem_q;
    end

    // Full 64-bit products; the operands are extended explicitly so width is obvious.
    logic [63:0] prod_s, prod_u;
    always_comb begin
        prod_s = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
        prod_u = {32'd0, src_a} * {32'd0, src_b};
    end

    // Divider FSM and datapath; operands are latched only while IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quot_q  <= '0;
            dvsr_q  <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (div_op) begin
                        if (src_b == 32'd0) begin
                            // Divide by zero: fixed result, skip the iterations.
                            quot_q  <= 32'hFFFF_FFFF;
                            rem_q   <= src_a;
                            qneg_q  <= 1'b0;
                            rneg_q  <= 1'b0;
                            state_q <= DIV_END;
                        end else begin
                            rem_q   <= '0;
                            quot_q  <= a_mag;
                            dvsr_q  <= b_mag;
                            qneg_q  <= a_neg ^ b_neg;
                            rneg_q  <= a_neg;
                            cnt_q   <= '0;
                            state_q <= DIV_ON;
                        end
                    end
                end
                DIV_ON: begin
                    rem_q  <= step_rem;
                    quot_q <= step_quot;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DIV_ITERS - 1))
                        state_q <= DIV_END;
                end
                DIV_END: begin
                    // Result stays put until the divide actually leaves EX.
                    if (adv)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // HI/LO next state: written only on an advancing edge, so each instruction commits once.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (adv) begin
            if (state_q == DIV_END) begin
                hi_d = rem_res;
                lo_d = quot_res;
            end else if (inst_mult) begin
                hi_d = prod_s[63:32];
                lo_d = prod_s[31:0];
            end else if (inst_multu) begin
                hi_d = prod_u[63:32];
                lo_d = prod_u[31:0];
            end else begin
                if (inst_mthi) hi_d = src_a;
                if (inst_mtlo) lo_d = src_a;
            end
        end
    end

    // Architectural HI/LO registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    // Stall request looks only at FSM state and div flags, never at stall.
    assign stallreq_for_ex = ((state_q == IDLE) & div_op) | (state_q == DIV_ON);
    assign div_busy        = (state_q != IDLE);

    // MFHI/MFLO read path into the EX writeback mux.
    always_comb begin
        hilo_rdata = 32'd0;
        if (inst_mfhi)      hilo_rdata = hi_q;
        else if (inst_mflo) hilo_rdata = lo_q;
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: doc/ex_hilo_muldiv.md
Name: ex_hilo_muldiv

Overview:
- Multiply/divide and HI/LO register unit instantiated inside the EX stage. It consumes the mult/div/mfhi/mflo/mthi/mtlo flags and the rs/rt operands that ID places on id_to_ex_bus.
- MULT/MULTU complete in a single cycle. DIV/DIVU use a 32-iteration restoring divider and hold the pipeline through stallreq_for_ex.
- It owns the architectural HI/LO registers and supplies the MFHI/MFLO result to the EX writeback mux.

Parameters:
- DIV_ITERS, 32, number of quotient bits produced (one per cycle).
- STALL_WD, 6, width of the stall bus (`StallBus).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- stall  in  STALL_WD  pipeline stall vector from ctrl; bit 2 = EX held (`Stop=1)
- inst_mult  in  1  signed multiply in EX
- inst_multu  in  1  unsigned multiply in EX
- inst_div  in  1  signed divide in EX
- inst_divu  in  1  unsigned divide in EX
- inst_mfhi  in  1  read HI
- inst_mflo  in  1  read LO
- inst_mthi  in  1  write HI from src_a
- inst_mtlo  in  1  write LO from src_a
- src_a  in  32  rs operand (forwarded rdata1)
- src_b  in  32  rt operand (forwarded rdata2)
- hilo_rdata  out  32  HI when inst_mfhi, LO when inst_mflo, else 0 (combinational)
- stallreq_for_ex  out  1  EX stall request to ctrl (combinational)
- div_busy  out  1  divider FSM is not IDLE
- hi_o  out  32  current HI (debug)
- lo_o  out  32  current LO (debug)

Behaviour:
- Reset (async, rst=1): HI=0, LO=0, FSM=IDLE, counter=0, all divider datapath registers 0. Resulting outputs: stallreq_for_ex=0, div_busy=0, hi_o=lo_o=0. A reset mid-division abandons it; HI/LO are not written.
- Let `adv` = (stall[2]==NoStop). HI/LO change only on a rising edge where adv=1, so an instruction commits HI/LO exactly once, when it leaves EX.
- MULT: {HI,LO} <= signed 64-bit product src_a*src_b.
- MULTU: {HI,LO} <= unsigned product. Single cycle, no stall.
- MTHI: HI <= src_a. MTLO: LO <= src_a. Other register untouched.
- MFHI/MFLO: pure read of the current register value. An instruction following a mult/mthi into EX sees the updated value (written at the prior edge); no forwarding is needed.
- Divider FSM states: IDLE, DIV_ON, DIV_END.
  - IDLE, (inst_div|inst_divu), src_b!=0: latch |dividend|, |divisor| (magnitudes for DIV; raw values for DIVU), quotient sign = sign(a)^sign(b), remainder sign = sign(a); counter=0; go to DIV_ON. stallreq_for_ex=1 this cycle.
  - IDLE, div op, src_b==0: go to DIV_END with result quotient=32'hFFFFFFFF, remainder=src_a. stallreq_for_ex=1 this cycle.
  - DIV_ON: one restoring step per cycle. Shift {rem,quot} left by 1; if rem>=divisor then subtract and set quotient LSB. Counter increments; after DIV_ITERS steps go to DIV_END. stallreq_for_ex=1 throughout.
  - DIV_END: apply sign fix-ups (two's-complement negate when the sign flag is set). stallreq_for_ex=0.
    - If adv: HI<=remainder, LO<=quotient, go to IDLE.
    - If !adv (downstream stall): hold in DIV_END with the result stable; the same div must not restart.
- Latency: a divide occupies EX for 34 cycles (1 issue + 32 iterate + 1 end). Divide-by-zero occupies EX for 2 cycles.
- DIV of 0x80000000 by 0xFFFFFFFF: magnitude path yields quotient 0x80000000, remainder 0.
- stallreq_for_ex depends only on FSM state and div flags, never on stall, so no combinational loop through ctrl.
- Operand values during DIV_ON/DIV_END are ignored; the operands are latched in IDLE.

Test Plan:
- MULT, src_a=0xFFFFFFFE (-2), src_b=3, adv=1 -> next cycle HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV, src_a=0xFFFFFFF9 (-7), src_b=2 -> stallreq_for_ex=1 for exactly 33 cycles, then 0; after commit LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 -> LO=14, HI=2.
- DIVU, src_b=0, src_a=0x1234 -> stallreq_for_ex high 1 cycle; LO=0xFFFFFFFF, HI=0x1234.
- DIV reaches DIV_END while stall[2]=1 for 3 cycles -> HI/LO unchanged, FSM stays DIV_END, no restart; commits on first adv edge. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI src_a=0xAA with stall[2]=1 -> HI unchanged; release -> HI=0xAA; then MFHI -> hilo_rdata=0xAA. MFLO reads LO; with no mf flag asserted, hilo_rdata=0.
- Assert rst at iteration 10 of a DIV -> immediately FSM=IDLE, stallreq_for_ex=0, HI=LO=0; next DIV runs the full 34 cycles correctly.
